// File: rtl/udp_rx.sv
// RMII receive path: dibit deserialiser, preamble/SFD search, Ethernet/IPv4/UDP
// header filter, payload streaming and FCS residue check.
module udp_rx #(
  parameter logic [47:0] mac_my_adr  = 48'he86a64fad17b,
  parameter logic [31:0] my_ip_adr   = 32'hC0A80F0E,
  parameter logic [15:0] udp_my_port = 16'd11451,
  parameter logic [15:0] max_payload = 16'd1472
) (
  input  logic        I_clk50m,
  input  logic        I_rst,
  input  logic [1:0]  I_rxd,
  input  logic        I_crs_dv,
  output logic [7:0]  O_data,
  output logic        O_valid,
  output logic        O_sof,
  output logic        O_eof,
  output logic [15:0] O_len,
  output logic [31:0] O_src_ip,
  output logic [15:0] O_src_port,
  output logic        O_done,
  output logic        O_crc_ok,
  output logic        O_busy
);

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, TRAILER, DROP} state_t;

  state_t      state, state_n;
  logic [1:0]  dcnt;
  logic [5:0]  sh;
  logic [5:0]  hcnt;
  logic [15:0] pcnt;
  logic [31:0] crc;
  logic        mac_hit, bc_hit;
  logic [31:0] ip_cap;
  logic [15:0] port_cap, len_cap;
  logic        in_frame, shift_en, byte_done, frame_end, hdr_fail, last_byte;
  logic [7:0]  rx_byte, exp_byte;
  logic        exp_chk;
  logic [15:0] udp_len, pay_len;
  logic        valid_n, sof_n, eof_n, done_n, crc_ok_n;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // A low CRS_DV only ends the frame on a byte boundary; mid-byte lows are RMII toggling.
  assign in_frame  = (state == HEADER) || (state == PAYLOAD) || (state == TRAILER) || (state == DROP);
  assign shift_en  = in_frame && (I_crs_dv || (dcnt != 2'd0));
  assign byte_done = shift_en && (dcnt == 2'd3);
  assign frame_end = in_frame && !I_crs_dv && (dcnt == 2'd0);
  assign rx_byte   = {I_rxd, sh};
  assign udp_len   = {len_cap[7:0], rx_byte};
  assign pay_len   = len_cap - 16'd8;
  assign last_byte = (pcnt == pay_len - 16'd1);

  always_comb begin
    exp_chk  = 1'b1;
    exp_byte = 8'h00;
    case (hcnt)
      6'd0:  begin exp_chk = 1'b0; exp_byte = mac_my_adr[47:40]; end
      6'd1:  begin exp_chk = 1'b0; exp_byte = mac_my_adr[39:32]; end
      6'd2:  begin exp_chk = 1'b0; exp_byte = mac_my_adr[31:24]; end
      6'd3:  begin exp_chk = 1'b0; exp_byte = mac_my_adr[23:16]; end
      6'd4:  begin exp_chk = 1'b0; exp_byte = mac_my_adr[15:8];  end
      6'd5:  begin exp_chk = 1'b0; exp_byte = mac_my_adr[7:0];   end
      6'd12: exp_byte = 8'h08;
      6'd13: exp_byte = 8'h00;
      6'd14: exp_byte = 8'h45;
      6'd23: exp_byte = 8'h11;
      6'd30: exp_byte = my_ip_adr[31:24];
      6'd31: exp_byte = my_ip_adr[23:16];
      6'd32: exp_byte = my_ip_adr[15:8];
      6'd33: exp_byte = my_ip_adr[7:0];
      6'd36: exp_byte = udp_my_port[15:8];
      6'd37: exp_byte = udp_my_port[7:0];
      default: exp_chk = 1'b0;
    endcase
  end

  // Destination MAC must match the local address or broadcast across all six bytes.
  always_comb begin
    hdr_fail = 1'b0;
    if (exp_chk && (rx_byte != exp_byte))
      hdr_fail = 1'b1;
    if ((hcnt == 6'd5) && !((mac_hit && (rx_byte == exp_byte)) || (bc_hit && (rx_byte == 8'hFF))))
      hdr_fail = 1'b1;
    if ((hcnt == 6'd39) && ((udp_len < 16'd9) || ((udp_len - 16'd8) > max_payload)))
      hdr_fail = 1'b1;
  end

  always_ff @(posedge I_clk50m or negedge I_rst) begin
    if (!I_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (I_crs_dv && (I_rxd == 2'b01)) state_n = PREAMBLE;
      PREAMBLE: if (!I_crs_dv)              state_n = IDLE;
                else if (I_rxd == 2'b11)    state_n = HEADER;
                else if (I_rxd != 2'b01)    state_n = IDLE;
      HEADER:   if (frame_end)                              state_n = IDLE;
                else if (byte_done && hdr_fail)             state_n = DROP;
                else if (byte_done && (hcnt == 6'd41))      state_n = PAYLOAD;
      PAYLOAD:  if (frame_end)                              state_n = IDLE;
                else if (byte_done && last_byte)            state_n = TRAILER;
      TRAILER:  if (frame_end) state_n = IDLE;
      DROP:     if (frame_end) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    valid_n  = 1'b0;
    sof_n    = 1'b0;
    eof_n    = 1'b0;
    done_n   = 1'b0;
    crc_ok_n = 1'b0;
    O_busy   = in_frame;
    if ((state == PAYLOAD) && byte_done) begin
      valid_n = 1'b1;
      sof_n   = (pcnt == 16'd0);
      eof_n   = last_byte;
    end
    if (frame_end && (state == TRAILER)) begin
      done_n   = 1'b1;
      crc_ok_n = (crc == CRC_RESIDUE);
    end
    if (frame_end && (state == PAYLOAD))
      done_n = 1'b1;
  end

  always_ff @(posedge I_clk50m or negedge I_rst) begin
    if (!I_rst) begin
      O_data     <= 8'h00;
      O_valid    <= 1'b0;
      O_sof      <= 1'b0;
      O_eof      <= 1'b0;
      O_len      <= 16'h0;
      O_src_ip   <= 32'h0;
      O_src_port <= 16'h0;
      O_done     <= 1'b0;
      O_crc_ok   <= 1'b0;
      dcnt       <= 2'd0;
      sh         <= 6'h0;
      hcnt       <= 6'd0;
      pcnt       <= 16'd0;
      crc        <= 32'hFFFFFFFF;
      mac_hit    <= 1'b1;
      bc_hit     <= 1'b1;
      ip_cap     <= 32'h0;
      port_cap   <= 16'h0;
      len_cap    <= 16'h0;
    end else begin
      O_valid <= valid_n;
      O_sof   <= sof_n;
      O_eof   <= eof_n;
      O_done  <= done_n;
      if (valid_n) O_data <= rx_byte;
      if (sof_n) begin
        O_len      <= pay_len;
        O_src_ip   <= ip_cap;
        O_src_port <= port_cap;
        O_crc_ok   <= 1'b0;
      end
      if (done_n) O_crc_ok <= crc_ok_n;

      if (!in_frame) dcnt <= 2'd0;
      else if (shift_en) begin
        dcnt <= dcnt + 2'd1;
        sh   <= {I_rxd, sh[5:2]};
      end

      if (state == PREAMBLE) begin
        hcnt    <= 6'd0;
        pcnt    <= 16'd0;
        crc     <= 32'hFFFFFFFF;
        mac_hit <= 1'b1;
        bc_hit  <= 1'b1;
      end else if (byte_done) begin
        crc <= crc_byte(crc, rx_byte);
        if (state == HEADER) begin
          hcnt <= hcnt + 6'd1;
          if (hcnt < 6'd6) begin
            mac_hit <= mac_hit && (rx_byte == exp_byte);
            bc_hit  <= bc_hit && (rx_byte == 8'hFF);
          end
          case (hcnt)
            6'd26, 6'd27, 6'd28, 6'd29: ip_cap   <= {ip_cap[23:0], rx_byte};
            6'd34, 6'd35:               port_cap <= {port_cap[7:0], rx_byte};
            6'd38, 6'd39:               len_cap  <= {len_cap[7:0], rx_byte};
            default: ;
          endcase
        end
        if (state == PAYLOAD) pcnt <= pcnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_rx.sv
// Scoreboard bench for udp_rx: frames are built as byte lists, a reference model
// predicts the payload/done events, and a monitor compares them as the DUT emits them.
module tb_udp_rx;

  localparam logic [47:0] MY_MAC  = 48'he86a64fad17b;
  localparam logic [31:0] MY_IP   = 32'hC0A80F0E;
  localparam logic [15:0] MY_PORT = 16'd11451;
  localparam int          MAX_PAY = 1472;

  logic        I_clk50m, I_rst, I_crs_dv;
  logic [1:0]  I_rxd;
  logic [7:0]  O_data;
  logic        O_valid, O_sof, O_eof, O_done, O_crc_ok, O_busy;
  logic [15:0] O_len, O_src_port;
  logic [31:0] O_src_ip;

  udp_rx dut (
    .I_clk50m(I_clk50m), .I_rst(I_rst), .I_rxd(I_rxd), .I_crs_dv(I_crs_dv),
    .O_data(O_data), .O_valid(O_valid), .O_sof(O_sof), .O_eof(O_eof),
    .O_len(O_len), .O_src_ip(O_src_ip), .O_src_port(O_src_port),
    .O_done(O_done), .O_crc_ok(O_crc_ok), .O_busy(O_busy)
  );

  initial I_clk50m = 1'b0;
  always #10 I_clk50m = ~I_clk50m;

  typedef struct {
    bit          is_done;
    logic [7:0]  data;
    bit          sof;
    bit          eof;
    logic [15:0] len;
    logic [31:0] ip;
    logic [15:0] port;
    bit          crc_ok;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] frame[$];
  logic [7:0] pay[$];
  int         checks = 0;
  int         failures = 0;
  int         since_valid = 0;
  bit         exp_crc_hold = 1'b0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc32_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_n(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frame.push_back(v[8*i +: 8]);
  endtask

  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype, input logic [7:0] proto,
                             input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sport,
                             input logic [15:0] dport, input logic [15:0] ulen);
    logic [31:0] fcs;
    int pad;
    frame.delete();
    push_n(dmac, 6);
    push_n(48'h020000000001, 6);
    push_n({32'h0, etype}, 2);
    push_n(48'h45, 1);
    push_n(48'h0, 1);
    push_n(48'(28 + pay.size()), 2);
    push_n(48'h1234, 2);
    push_n(48'h4000, 2);
    push_n(48'h40, 1);
    push_n({40'h0, proto}, 1);
    push_n(48'h0, 2);
    push_n({16'h0, sip}, 4);
    push_n({16'h0, dip}, 4);
    push_n({32'h0, sport}, 2);
    push_n({32'h0, dport}, 2);
    push_n({32'h0, ulen}, 2);
    push_n(48'h0, 2);
    foreach (pay[i]) frame.push_back(pay[i]);
    pad = 46 - (28 + pay.size());
    for (int i = 0; i < pad; i++) frame.push_back(8'h00);
    fcs = crc32_of(frame.size());
    for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
  endtask

  // Reference model: decide acceptance from the header fields and predict the event stream.
  task automatic predict(input int nbytes, input bit by_reset);
    logic [47:0] dmac;
    logic [31:0] dip, sip;
    logic [15:0] ulen, sport, dport;
    logic [31:0] fcs_rx;
    bit          ok, crc_ok;
    int          plen, nout, n;
    exp_t        e;
    if (nbytes < 42) return;
    dmac = '0; sip = '0; dip = '0;
    for (int i = 0; i < 6; i++) dmac = {dmac[39:0], frame[i]};
    for (int i = 26; i < 30; i++) sip = {sip[23:0], frame[i]};
    for (int i = 30; i < 34; i++) dip = {dip[23:0], frame[i]};
    sport = {frame[34], frame[35]};
    dport = {frame[36], frame[37]};
    ulen  = {frame[38], frame[39]};
    ok = (dmac == MY_MAC || dmac == 48'hFFFFFFFFFFFF) && frame[12] == 8'h08 && frame[13] == 8'h00 &&
         frame[14] == 8'h45 && frame[23] == 8'h11 && dip == MY_IP && dport == MY_PORT &&
         ulen >= 9 && int'(ulen) - 8 <= MAX_PAY;
    if (!ok) return;
    plen = int'(ulen) - 8;
    nout = (nbytes - 42 < plen) ? nbytes - 42 : plen;
    for (int i = 0; i < nout; i++) begin
      e = '{is_done: 1'b0, data: frame[42+i], sof: (i == 0), eof: (i == plen - 1),
            len: 16'(plen), ip: sip, port: sport, crc_ok: 1'b0};
      exp_q.push_back(e);
    end
    if (nout > 0) exp_crc_hold = 1'b0;
    if (by_reset) return;
    n = nbytes;
    fcs_rx = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
    crc_ok = (n >= 42 + plen + 4) && (crc32_of(n - 4) == fcs_rx);
    e = '{is_done: 1'b1, data: 8'h0, sof: 1'b0, eof: 1'b0, len: 16'h0, ip: 32'h0, port: 16'h0, crc_ok: crc_ok};
    exp_q.push_back(e);
    exp_crc_hold = crc_ok;
  endtask

  task automatic applyStimulus(input logic [1:0] d, input logic dv);
    @(posedge I_clk50m);
    #1;
    I_rxd = d;
    I_crs_dv = dv;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) applyStimulus(b[2*k +: 2], 1'b1);
  endtask

  task automatic checkOutput();
    check("reset_strobes", {O_valid, O_sof, O_eof, O_done, O_crc_ok, O_busy}, 48'h0);
    check("reset_data_len", {O_data, O_len}, 48'h0);
    check("reset_src", {O_src_ip, O_src_port}, 48'h0);
  endtask

  // Sends the first nbytes of the frame; ends by dropping CRS_DV or by a mid-byte reset.
  task automatic run_frame(input int nbytes, input bit by_reset);
    predict(nbytes, by_reset);
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(frame[i]);
      if (i == 10) check("busy_in_header", O_busy, 1);
    end
    if (by_reset) begin
      applyStimulus(frame[nbytes][1:0], 1'b1);
      applyStimulus(frame[nbytes][3:2], 1'b1);
      @(posedge I_clk50m);
      #1;
      I_rst = 1'b0;
      I_crs_dv = 1'b0;
      repeat (2) @(negedge I_clk50m);
      checkOutput();
      exp_crc_hold = 1'b0;
      @(posedge I_clk50m);
      #1;
      I_rst = 1'b1;
    end else begin
      applyStimulus(2'b00, 1'b0);
    end
    repeat (16) @(posedge I_clk50m);
    #1;
    check("pending_events", exp_q.size(), 0);
    check("busy_after_frame", O_busy, 0);
    check("crc_ok_hold", O_crc_ok, exp_crc_hold);
  endtask

  task automatic make_payload(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // Monitor: pops one expectation per O_valid / O_done and compares it.
  always @(negedge I_clk50m) begin
    since_valid++;
    if (O_valid) begin
      if (exp_q.size() == 0 || exp_q[0].is_done) begin
        check("unexpected_byte", {O_sof, O_eof, O_data}, 48'hFFFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("data", O_data, mon_e.data);
        check("sof", O_sof, mon_e.sof);
        check("eof", O_eof, mon_e.eof);
        if (mon_e.sof) begin
          check("len", O_len, mon_e.len);
          check("src_ip", O_src_ip, mon_e.ip);
          check("src_port", O_src_port, mon_e.port);
        end else begin
          check("byte_spacing", since_valid, 4);
        end
      end
      since_valid = 0;
    end
    if (O_done) begin
      if (exp_q.size() == 0 || !exp_q[0].is_done) begin
        check("unexpected_done", O_done, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_crc_ok", O_crc_ok, mon_e.crc_ok);
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [47:0] dmac;
    logic [31:0] dip;
    logic [15:0] etype, dport, sport;
    logic [7:0]  proto;
    int          v, idx;
    I_rst = 1'b0;
    I_crs_dv = 1'b0;
    I_rxd = 2'b00;
    repeat (3) @(negedge I_clk50m);
    checkOutput();
    @(posedge I_clk50m);
    #1;
    I_rst = 1'b1;
    repeat (4) @(posedge I_clk50m);

    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build_frame(MY_MAC, 16'h0800, 8'h11, 32'hC0A80F0F, MY_IP, 16'd11451, MY_PORT, 16'd12);
    run_frame(frame.size(), 1'b0);

    frame[43] = frame[43] ^ 8'h10;
    run_frame(frame.size(), 1'b0);

    build_frame(MY_MAC, 16'h0800, 8'h11, 32'hC0A80F0F, MY_IP, 16'd11451, 16'd1234, 16'd12);
    run_frame(frame.size(), 1'b0);
    build_frame(MY_MAC, 16'h0800, 8'h11, 32'hC0A80F0F, 32'hC0A80F63, 16'd11451, MY_PORT, 16'd12);
    run_frame(frame.size(), 1'b0);
    build_frame(MY_MAC, 16'h0806, 8'h11, 32'hC0A80F0F, MY_IP, 16'd11451, MY_PORT, 16'd12);
    run_frame(frame.size(), 1'b0);

    pay = '{8'h5A};
    build_frame(48'hFFFFFFFFFFFF, 16'h0800, 8'h11, 32'hC0A80F01, MY_IP, 16'd4000, MY_PORT, 16'd9);
    run_frame(frame.size(), 1'b0);

    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build_frame(MY_MAC, 16'h0800, 8'h11, 32'hC0A80F0F, MY_IP, 16'd11451, MY_PORT, 16'd12);
    run_frame(44, 1'b0);
    run_frame(frame.size(), 1'b0);
    run_frame(44, 1'b1);
    run_frame(frame.size(), 1'b0);

    build_frame(MY_MAC, 16'h0800, 8'h11, 32'hC0A80F0F, MY_IP, 16'd11451, MY_PORT, 16'd8);
    run_frame(frame.size(), 1'b0);
    build_frame(MY_MAC, 16'h0800, 8'h11, 32'hC0A80F0F, MY_IP, 16'd11451, MY_PORT, 16'(MAX_PAY + 9));
    run_frame(frame.size(), 1'b0);
    make_payload(MAX_PAY);
    build_frame(MY_MAC, 16'h0800, 8'h11, 32'hC0A80F22, MY_IP, 16'd777, MY_PORT, 16'(MAX_PAY + 8));
    run_frame(frame.size(), 1'b0);

    for (int n = 0; n < 16; n++) begin
      make_payload($urandom_range(1, 24));
      dmac = MY_MAC; etype = 16'h0800; proto = 8'h11; dip = MY_IP; dport = MY_PORT;
      sport = 16'($urandom_range(0, 65535));
      v = $urandom_range(0, 7);
      case (v)
        1: dmac = 48'hFFFFFFFFFFFF;
        2: dport = MY_PORT ^ 16'(1 << $urandom_range(0, 15));
        3: dip = MY_IP ^ (32'h1 << $urandom_range(0, 31));
        4: etype = 16'h0806;
        6: dmac = MY_MAC ^ (48'h1 << $urandom_range(0, 47));
        7: proto = 8'h06;
        default: ;
      endcase
      build_frame(dmac, etype, proto, $urandom, dip, sport, dport, 16'(8 + pay.size()));
      if (v == 5) begin
        idx = 42 + $urandom_range(0, pay.size() - 1);
        frame[idx] = frame[idx] ^ (8'h1 << $urandom_range(0, 7));
      end
      run_frame(frame.size(), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
